// File: rtl/alu_shift_pipe_pkg.sv
// Shared ALU definitions: shift opcode encodings and stage payload field widths.
// Opcodes 00/01/11 keep their existing ALU meanings; 10 (ROR) is the newest addition.
package alu_defs;

  localparam int CTRL_W = 2;
  localparam int SIGN_W = 1;

  typedef enum logic [CTRL_W-1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_ROR = 2'b10,
    SHIFT_SRA = 2'b11
  } shift_op_e;

endpackage

// File: rtl/alu_shift_pipe_stage.sv
// One barrel-shifter layer (shift by DIST when its amount bit is set) plus its payload register.
// Latency 1 cycle; loads when empty or when downstream takes, so backpressure ripples combinationally.
module shift_stage
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 16,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     up_valid,
  output logic                     up_ready,
  input  logic [WIDTH-1:0]         up_data,
  input  logic [$clog2(WIDTH)-1:0] up_shamt,
  input  shift_op_e                up_ctrl,
  input  logic [SIGN_W-1:0]        up_sign,
  input  logic [TAG_W-1:0]         up_tag,
  output logic                     dn_valid,
  input  logic                     dn_ready,
  output logic [WIDTH-1:0]         dn_data,
  output logic [$clog2(WIDTH)-1:0] dn_shamt,
  output shift_op_e                dn_ctrl,
  output logic [SIGN_W-1:0]        dn_sign,
  output logic [TAG_W-1:0]         dn_tag
);

  localparam int SEL = $clog2(DIST);

  logic             load;
  logic [WIDTH-1:0] layer;

  assign load     = !dn_valid || dn_ready;
  assign up_ready = load && !flush;

  always_comb begin
    layer = up_data;
    if (up_shamt[SEL]) begin
      case (up_ctrl)
        SHIFT_SLL: layer = {up_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SHIFT_SRL: layer = {{DIST{1'b0}}, up_data[WIDTH-1:DIST]};
        // sign was captured at acceptance, so every layer fills with the original MSB
        SHIFT_SRA: layer = {{DIST{up_sign[0]}}, up_data[WIDTH-1:DIST]};
        SHIFT_ROR: layer = {up_data[DIST-1:0], up_data[WIDTH-1:DIST]};
        default:   layer = up_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_shamt <= '0;
      dn_ctrl  <= SHIFT_SLL;
      dn_sign  <= '0;
      dn_tag   <= '0;
    end else if (flush) begin
      dn_valid <= 1'b0;
    end else if (load) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data  <= layer;
        dn_shamt <= up_shamt;
        dn_ctrl  <= up_ctrl;
        dn_sign  <= up_sign;
        dn_tag   <= up_tag;
      end
    end
  end

endmodule

// File: rtl/alu_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with a tag carried alongside each result.
// Latency SHAMT_W cycles, 1 op/cycle; out_ready backpressure stalls the chain without bubbles.
module alu_shift_pipe
  import alu_defs::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SHAMT_W-1:0] A,
  input  logic [WIDTH-1:0]   B,
  input  logic [CTRL_W-1:0]  ctrl,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [TAG_W-1:0]   out_tag
);

  if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt
    $error("alu_shift_pipe: SHAMT_W must equal clog2(WIDTH)");
  end
  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_shift_pipe: WIDTH must be a power of two and at least 8");
  end

  logic [SHAMT_W:0]                vld;
  logic [SHAMT_W:0]                rdy;
  logic [SHAMT_W:0][WIDTH-1:0]     dat;
  logic [SHAMT_W:0][SHAMT_W-1:0]   sh;
  logic [SHAMT_W:0][SIGN_W-1:0]    sgn;
  logic [SHAMT_W:0][TAG_W-1:0]     tg;
  shift_op_e                       op [SHAMT_W+1];
  logic                            unused_tail;

  assign vld[0]       = in_valid;
  assign dat[0]       = B;
  assign sh[0]        = A;
  assign op[0]        = shift_op_e'(ctrl);
  assign sgn[0]       = B[WIDTH-1];
  assign tg[0]        = in_tag;
  assign rdy[SHAMT_W] = out_ready;

  assign in_ready    = rdy[0];
  assign out_valid   = vld[SHAMT_W];
  assign result      = dat[SHAMT_W];
  assign out_tag     = tg[SHAMT_W];
  assign unused_tail = ^{sh[SHAMT_W], sgn[SHAMT_W], op[SHAMT_W]};

  // largest distance first: 16, 8, 4, 2, 1 for a 32-bit datapath
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH(WIDTH),
      .DIST (1 << (SHAMT_W - 1 - k)),
      .TAG_W(TAG_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .up_valid(vld[k]),
      .up_ready(rdy[k]),
      .up_data (dat[k]),
      .up_shamt(sh[k]),
      .up_ctrl (op[k]),
      .up_sign (sgn[k]),
      .up_tag  (tg[k]),
      .dn_valid(vld[k+1]),
      .dn_ready(rdy[k+1]),
      .dn_data (dat[k+1]),
      .dn_shamt(sh[k+1]),
      .dn_ctrl (op[k+1]),
      .dn_sign (sgn[k+1]),
      .dn_tag  (tg[k+1])
    );
  end

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Bench for alu_shift_pipe: directed vectors and corner sequences on a 32-bit instance,
// random scoreboard against a plain-arithmetic shift model on both 32-bit and 8-bit instances.
module tb_alu_shift_pipe;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [1:0]      vld_i = '0;
  logic [1:0]      ordy = '0;
  logic [1:0]      rdy_o;
  logic [1:0]      ovld;
  logic [1:0][4:0] a_i = '0;
  logic [1:0][31:0] b_i = '0;
  logic [1:0][1:0] c_i = '0;
  logic [1:0][4:0] t_i = '0;
  logic [31:0]     res32;
  logic [7:0]      res8;
  logic [4:0]      otag32, otag8;

  always #5 clk = ~clk;

  alu_shift_pipe #(.WIDTH(32), .SHAMT_W(5), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(vld_i[0]), .in_ready(rdy_o[0]),
    .A(a_i[0]), .B(b_i[0]), .ctrl(c_i[0]), .in_tag(t_i[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .result(res32), .out_tag(otag32)
  );

  alu_shift_pipe #(.WIDTH(8), .SHAMT_W(3), .TAG_W(5)) dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(vld_i[1]), .in_ready(rdy_o[1]),
    .A(a_i[1][2:0]), .B(b_i[1][7:0]), .ctrl(c_i[1]), .in_tag(t_i[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .result(res8), .out_tag(otag8)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          acc;
  } exp_t;

  typedef struct {
    logic [1:0]  c;
    logic [4:0]  a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          stepn = 0;
  int          n_out = 0, first_out = 0, last_out = 0, n_acc = 0;
  int          wid [2] = '{32, 8};
  int          lat [2] = '{5, 3};
  exp_t        q0[$];
  exp_t        q1[$];
  bit          held [2];
  logic [31:0] hres [2];
  logic [4:0]  htag [2];
  bit          obs_v [2];
  logic [31:0] obs_r [2];
  bit          fl_prev = 1'b0;
  bit          chk_lat = 1'b0;
  vec_t        tbl [11];

  // Reference shift computed on a 64-bit value with a width mask
  function automatic logic [31:0] model(int w, logic [1:0] c, int a, logic [31:0] b);
    logic [63:0] m, x, r;
    m = (64'd1 << w) - 64'd1;
    x = {32'd0, b} & m;
    case (c)
      2'b00:   r = x << a;
      2'b01:   r = x >> a;
      2'b11:   r = x[w-1] ? ((x >> a) | (m & ~(m >> a))) : (x >> a);
      default: r = (x >> a) | (x << (w - a));
    endcase
    return 32'(r & m);
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h (step %0d)", nm, act, req, stepn);
    end
  endtask

  // Called in the low clock phase with inputs already driven; observes, then advances one cycle.
  task automatic step(input bit fl);
    exp_t        e;
    logic [31:0] r;
    logic [4:0]  tg;
    bit          ov;
    flush = fl;
    #1;
    for (int d = 0; d < 2; d++) begin
      r  = (d == 0) ? res32 : {24'd0, res8};
      tg = (d == 0) ? otag32 : otag8;
      ov = ovld[d];
      obs_v[d] = ov;
      obs_r[d] = r;
      if (held[d]) begin
        chk(ov, $sformatf("hold_valid%0d", d), 32'(ov), 32'd1);
        chk(r == hres[d], $sformatf("hold_result%0d", d), r, hres[d]);
        chk(tg == htag[d], $sformatf("hold_tag%0d", d), 32'(tg), 32'(htag[d]));
      end
      if (fl_prev) chk(!ov, $sformatf("flush_out_valid%0d", d), 32'(ov), 32'd0);
      if (ov && ordy[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          chk(1'b0, $sformatf("unexpected_output%0d", d), r, 32'd0);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk(r == e.res, $sformatf("result%0d", d), r, e.res);
          chk(tg == e.tag, $sformatf("tag%0d", d), 32'(tg), 32'(e.tag));
          if (chk_lat) chk(stepn - e.acc == lat[d], $sformatf("latency%0d", d),
                           32'(stepn - e.acc), 32'(lat[d]));
        end
        if (d == 0) begin
          if (n_out == 0) first_out = stepn;
          last_out = stepn;
          n_out++;
        end
      end
      held[d] = ov && !ordy[d] && !fl;
      hres[d] = r;
      htag[d] = tg;
      if (fl) begin
        chk(!rdy_o[d], $sformatf("flush_in_ready%0d", d), 32'(rdy_o[d]), 32'd0);
        if (d == 0) q0.delete();
        else        q1.delete();
      end else if (vld_i[d] && rdy_o[d]) begin
        e.res = model(wid[d], c_i[d], int'(a_i[d]), b_i[d]);
        e.tag = t_i[d];
        e.acc = stepn;
        if (d == 0) begin
          q0.push_back(e);
          n_acc++;
        end else begin
          q1.push_back(e);
        end
      end
    end
    fl_prev = fl;
    stepn++;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    vld_i = '0;
    rst = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk(!ovld[d], $sformatf("rst_out_valid%0d", d), 32'(ovld[d]), 32'd0);
      chk(((d == 0) ? otag32 : otag8) == 5'd0, $sformatf("rst_out_tag%0d", d),
          32'((d == 0) ? otag32 : otag8), 32'd0);
      held[d] = 1'b0;
    end
    chk(res32 == 32'd0, "rst_result32", res32, 32'd0);
    chk(res8 == 8'd0, "rst_result8", 32'(res8), 32'd0);
    q0.delete();
    q1.delete();
    fl_prev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      chk(rdy_o[d], $sformatf("in_ready_after_rst%0d", d), 32'(rdy_o[d]), 32'd1);
  endtask

  task automatic run_one(input vec_t v, input string nm);
    int n;
    ordy[0] = 1'b1;
    vld_i[0] = 1'b1;
    c_i[0] = v.c;
    a_i[0] = v.a;
    b_i[0] = v.b;
    t_i[0] = 5'(v.a ^ 5'h15);
    step(1'b0);
    vld_i[0] = 1'b0;
    n = 0;
    do begin
      step(1'b0);
      n++;
    end while (!obs_v[0] && n < 12);
    chk(obs_v[0], {nm, "_timeout"}, 32'(obs_v[0]), 32'd1);
    chk(obs_r[0] == v.exp, {nm, "_result"}, obs_r[0], v.exp);
    chk(n == 5, {nm, "_cycles"}, 32'(n), 32'd5);
  endtask

  initial begin
    tbl[0]  = '{2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000};
    tbl[1]  = '{2'b00, 5'd0,  32'h1234_5678, 32'h1234_5678};
    tbl[2]  = '{2'b11, 5'd4,  32'h8000_0000, 32'hF800_0000};
    tbl[3]  = '{2'b01, 5'd4,  32'h8000_0000, 32'h0800_0000};
    tbl[4]  = '{2'b11, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000};
    tbl[5]  = '{2'b10, 5'd4,  32'h0000_00F1, 32'h1000_000F};
    tbl[6]  = '{2'b10, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[7]  = '{2'b11, 5'd31, 32'h8000_0001, 32'hFFFF_FFFF};
    tbl[8]  = '{2'b10, 5'd31, 32'h8000_0001, 32'h0000_0003};
    tbl[9]  = '{2'b00, 5'd16, 32'hFFFF_FFFF, 32'hFFFF_0000};
    tbl[10] = '{2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001};

    @(negedge clk);
    do_reset();

    chk_lat = 1'b1;
    for (int i = 0; i < 11; i++) run_one(tbl[i], $sformatf("vec%0d", i));

    // back-to-back stream of 8 ops
    n_out = 0;
    ordy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vld_i[0] = 1'b1;
      c_i[0] = 2'($urandom_range(0, 3));
      a_i[0] = 5'($urandom_range(0, 31));
      b_i[0] = $urandom;
      t_i[0] = 5'(i + 3);
      step(1'b0);
    end
    vld_i[0] = 1'b0;
    for (int i = 0; i < 12 && q0.size() != 0; i++) step(1'b0);
    chk(n_out == 8, "b2b_count", 32'(n_out), 32'd8);
    chk(last_out - first_out == 7, "b2b_span", 32'(last_out - first_out), 32'd7);

    // backpressure: consumer stalls for 10 cycles while the producer keeps offering
    chk_lat = 1'b0;
    ordy[0] = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      vld_i[0] = 1'b1;
      c_i[0] = 2'($urandom_range(0, 3));
      a_i[0] = 5'($urandom_range(0, 31));
      b_i[0] = $urandom;
      t_i[0] = 5'(i);
      step(1'b0);
    end
    chk(n_acc == 5, "bp_accepted", 32'(n_acc), 32'd5);
    chk(!rdy_o[0], "bp_in_ready", 32'(rdy_o[0]), 32'd0);
    vld_i[0] = 1'b0;
    ordy[0] = 1'b1;
    for (int i = 0; i < 20 && q0.size() != 0; i++) step(1'b0);
    chk(q0.size() == 0, "bp_drain", 32'(q0.size()), 32'd0);

    // flush with 3 ops in flight while another op is offered
    for (int i = 0; i < 3; i++) begin
      vld_i[0] = 1'b1;
      b_i[0] = $urandom;
      a_i[0] = 5'(i + 1);
      t_i[0] = 5'(20 + i);
      step(1'b0);
    end
    step(1'b1);
    vld_i[0] = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0);

    // reset mid-stream, then a fresh op
    for (int i = 0; i < 3; i++) begin
      vld_i[0] = 1'b1;
      b_i[0] = $urandom;
      t_i[0] = 5'(25 + i);
      step(1'b0);
    end
    do_reset();
    chk_lat = 1'b1;
    run_one(tbl[5], "post_rst");
    chk_lat = 1'b0;

    // random scoreboard on both widths
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        vld_i[d] = ($urandom_range(0, 3) != 0);
        c_i[d]   = 2'($urandom_range(0, 3));
        a_i[d]   = (d == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        b_i[d]   = $urandom;
        t_i[d]   = 5'($urandom);
        ordy[d]  = ((i / 64) % 4 == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
      step($urandom_range(0, 199) == 0);
    end
    vld_i = '0;
    ordy = '1;
    for (int i = 0; i < 20; i++) step(1'b0);
    chk(q0.size() == 0, "rand_drain32", 32'(q0.size()), 32'd0);
    chk(q1.size() == 0, "rand_drain8", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
